// File: rtl/cpu_defs.sv
// Shared CPU constants: reset/exception vectors and fetch geometry.
package cpu_defs;

  localparam logic [31:0] PC_RESET_VEC    = 32'hbfc00000;
  localparam logic [31:0] EXC_VEC_RESET   = 32'hbfc00000;
  localparam logic [31:0] EXC_VEC_GENERAL = 32'hbfc00380;
  localparam int          PC_STEP         = 4;
  localparam int          PC_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_redirect_pend.sv
// Holds a branch target that could not be taken because fetch was not advancing.
module pc_redirect_pend #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] target_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] target_o
);

  // clear wins so a flush or a consuming advance never leaves a stale redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o  <= 1'b0;
      target_o <= '0;
    end else if (clear_i) begin
      valid_o  <= 1'b0;
    end else if (set_i) begin
      valid_o  <= 1'b1;
      target_o <= target_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: flush > branch > sequential, with a pending
// register so a branch seen while fetch is blocked is taken on the next accept.
module pc_gen
  import cpu_defs::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_VEC),
  parameter int               STEP       = PC_STEP,
  parameter int               ALIGN_BITS = PC_ALIGN_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] exc_target_i,
  input  logic             br_take_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             inst_addr_ok_i,
  output logic             inst_req_o,
  output logic [WIDTH-1:0] inst_addr_o,
  output logic             pc_adel_o,
  output logic             pend_valid_o
);

  logic [WIDTH-1:0] pc;
  logic             started;
  logic [WIDTH-1:0] pend_target;
  logic             advance;
  logic [WIDTH-1:0] next_pc;

  assign inst_addr_o  = pc;
  assign pc_adel_o    = |pc[ALIGN_BITS-1:0];
  assign inst_req_o   = started & ~stall_i & ~flush_i & ~pc_adel_o;
  assign advance      = inst_req_o & inst_addr_ok_i;

  // a fresh branch this cycle beats an older pending one
  assign next_pc = br_take_i    ? br_target_i :
                   pend_valid_o ? pend_target :
                                  pc + WIDTH'(STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (flush_i)
        pc <= exc_target_i;
      else if (advance)
        pc <= next_pc;
    end
  end

  pc_redirect_pend #(.WIDTH(WIDTH)) u_pend (
    .clk      (clk),
    .reset    (reset),
    .set_i    (br_take_i & ~advance & ~flush_i),
    .clear_i  (flush_i | advance),
    .target_i (br_target_i),
    .valid_o  (pend_valid_o),
    .target_o (pend_target)
  );

endmodule
